mem_access_master: RTL
======================

Name: mem_access_master

Overview:
- CPU-side initiator for the main-memory request/send protocol; the counterpart of the memory responder.
- Accepts one load/store command from the execute stage and drives request/bhw/WR_nRD/ADR/DATA until the responder pulses send.
- Returns sign- or zero-extended load data, or a store completion, with a one-cycle done pulse.
- Flags misalignment and responder timeout as errors.

Parameters:
- TIMEOUT, 255, max cycles request is held without send before aborting with err.
- GAP, 2, minimum idle cycles between deasserting request and the next request, so the responder's send edge detector re-arms.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous active-high reset.
- start  in  1  command valid; sampled only when busy=0.
- is_store  in  1  1=store, 0=load.
- funct3  in  3  RISC-V width code: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- addr  in  32  byte address.
- wdata  in  32  store data, low bytes used.
- busy  out  1  command in flight or in GAP.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done: misaligned, illegal funct3, or timeout.
- rdata  out  32  extended load result, valid with done.
- request  out  1  to memory.
- bhw  out  3  one-hot width: 001 byte, 010 half, 100 word.
- WR_nRD  out  1  1=write.
- ADR  out  32  to memory.
- DATA  out  32  to memory.
- DATAIN  in  32  responder DATAOUT.
- send  in  1  responder completion pulse.

Behaviour:
- Reset values: request=0, bhw=000, WR_nRD=0, ADR=0, DATA=0, busy=0, done=0, err=0, rdata=0, state=IDLE, counters=0.
- RST mid-transaction aborts immediately. request drops in the next cycle, and no done is produced.
- States: IDLE, REQ, GAP.
- IDLE with start=1:
  - Latch the command. bhw = 001 for funct3[1:0]=00, 010 for 01, 100 for 10.
  - Illegal funct3 (011, 11x, or 1xx with a store) -> done=1, err=1 next cycle; stay IDLE; no request.
  - Misaligned (half with addr[0]=1; word with addr[1:0]!=0) -> same as illegal funct3.
  - Otherwise -> REQ. request=1, ADR=addr, DATA=wdata, WR_nRD=is_store, and busy=1 from the next cycle.
- REQ:
  - Outputs are held stable. The timeout counter increments each cycle.
  - send=1 -> capture DATAIN. Next cycle: done=1, err=0, request=0 -> GAP.
  - Counter reaches TIMEOUT without send -> done=1, err=1, rdata=0, request=0 -> GAP.
  - send arriving in the same cycle as the timeout expiry counts as success.
- Load extension is applied to the low bytes of DATAIN; the responder is big-endian and returns values right-justified.
  - LB: sign-extend DATAIN[7:0].
  - LBU: zero-extend DATAIN[7:0].
  - LH: sign-extend DATAIN[15:0].
  - LHU: zero-extend DATAIN[15:0].
  - LW: DATAIN.
- Stores: rdata=0 at done.
- GAP: busy=1, request=0 for GAP cycles, then IDLE.
- start while busy=1 is ignored. The issuer must wait for busy=0.
- send outside REQ is ignored, with no error.
- Minimum load latency: start at cycle 0 -> request from cycle 1; with send at cycle k, done at k+1.
- done is never high for two consecutive cycles.

Decomposition:
- Shared package mem_pkg:
  - bhw encodings BHW_B=001, BHW_H=010, BHW_W=100.
  - funct3 codes.
  - State enum.
- One natural sub-module, load_extend: combinational funct3 + 32-bit data -> extended rdata. It is reusable by the pipeline's writeback.

Test Plan:
- LB from 0x10, responder returns DATAIN=0x000000F3 with send 2 cycles after request -> bhw=001, WR_nRD=0, ADR=0x10, done one cycle after send, rdata=0xFFFFFFF3, err=0.
- LHU 0x22 returns 0x0000ABCD -> rdata=0x0000ABCD. LH with the same data -> 0xFFFFABCD.
- SW 0x100 with wdata=0xDEADBEEF -> request held until send, DATA=0xDEADBEEF, bhw=100, WR_nRD=1, done with rdata=0; then request=0 for 2 cycles, busy=0 after.
- LW at 0x102 -> no request ever asserted, done=1 with err=1 one cycle after start. Also cover funct3=011 with the same response.
- Responder never sends, TIMEOUT=8 -> request high exactly 8 cycles, then done=1, err=1; next command proceeds normally.
- RST asserted in REQ -> next cycle request=0, busy=0, no done. start back-to-back while busy -> ignored, only the first command completes.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the CPU-side memory initiator: bus width codes,
// RISC-V load/store width codes, FSM state encodings and command decode helpers.
package mem_pkg;

  // One-hot access width presented on bhw.
  localparam logic [2:0] BHW_B = 3'b001;
  localparam logic [2:0] BHW_H = 3'b010;
  localparam logic [2:0] BHW_W = 3'b100;

  // RISC-V funct3 width codes for loads and stores.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // FSM state encodings.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  // Width code 11 never exists; unsigned variants exist only for B/H loads.
  function automatic logic f3_legal(input logic [2:0] f3, input logic st);
    return (f3[1:0] != 2'b11) && !(f3[2] && (f3[1] || st));
  endfunction

  // Halves need an even address, words a 4-byte aligned one.
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b01:   return a[0];
      2'b10:   return a != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] bhw_of(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return BHW_B;
      2'b01:   return BHW_H;
      default: return BHW_W;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_master_if.sv
// Request/send bus between the CPU-side initiator and the memory responder.
interface mem_access_master_if;
  logic        request;
  logic [2:0]  bhw;
  logic        WR_nRD;
  logic [31:0] ADR;
  logic [31:0] DATA;
  logic [31:0] DATAIN;
  logic        send;

  modport master (output request, bhw, WR_nRD, ADR, DATA, input DATAIN, send);
  modport slave  (input request, bhw, WR_nRD, ADR, DATA, output DATAIN, send);
endinterface

// File: rtl/mem_access_master_load_extend.sv
// Sign/zero extension of right-justified load data by funct3; purely combinational
// so the writeback stage can reuse it.
module load_extend
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] data,
  output logic [31:0] rdata
);

  // Select extension by width code; unknown codes yield zero.
  always_comb begin
    // NOTE: default assignment first so no path leaves rdata unassigned (no latch).
    rdata = '0;
    case (funct3)
      F3_B:    rdata = {{24{data[7]}}, data[7:0]};
      F3_BU:   rdata = {24'h0, data[7:0]};
      F3_H:    rdata = {{16{data[15]}}, data[15:0]};
      F3_HU:   rdata = {16'h0, data[15:0]};
      F3_W:    rdata = data;
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_master.sv
// CPU-side initiator: takes one load/store command, holds request on the memory
// bus until the responder pulses send (or a timeout expires), reports the result
// with a one-cycle done pulse, then idles GAP cycles so the responder re-arms.
module mem_access_master
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int GAP     = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  input  logic                 is_store,
  input  logic [2:0]           funct3,
  input  logic [31:0]          addr,
  input  logic [31:0]          wdata,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [31:0]          rdata,
  mem_access_master_if.master  bus
);

  // One counter serves both the REQ timeout and the GAP idle period.
  localparam int CNT_MAX = (TIMEOUT > GAP) ? TIMEOUT : GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          req_q;
  logic          wr_q;
  logic [2:0]    bhw_q;
  logic [2:0]    f3_q;
  logic [31:0]   adr_q;
  logic [31:0]   data_q;
  logic [31:0]   ext;

  assign bus.request = req_q;
  assign bus.WR_nRD  = wr_q;
  assign bus.bhw     = bhw_q;
  assign bus.ADR     = adr_q;
  assign bus.DATA    = data_q;

  // The done cycle of a rejected command also counts as busy, so a new start
  // cannot produce a second done in the very next cycle.
  assign busy = (state != ST_IDLE) || done;

  load_extend u_load_extend (
    .funct3 (f3_q),
    .data   (bus.DATAIN),
    .rdata  (ext)
  );

  // Command FSM: accept in IDLE, hold the bus in REQ, idle out in GAP.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      req_q  <= 1'b0;
      wr_q   <= 1'b0;
      bhw_q  <= 3'b000;
      f3_q   <= 3'b000;
      adr_q  <= '0;
      data_q <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
      rdata  <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout; later assignments in the
      // same cycle override these pulse defaults.
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !busy) begin
            f3_q <= funct3;
            if (!f3_legal(funct3, is_store) || f3_misaligned(funct3, addr[1:0])) begin
              done  <= 1'b1;
              err   <= 1'b1;
              rdata <= '0;
            end else begin
              state  <= ST_REQ;
              cnt    <= '0;
              req_q  <= 1'b1;
              wr_q   <= is_store;
              bhw_q  <= bhw_of(funct3);
              adr_q  <= addr;
              data_q <= wdata;
            end
          end
        end
        ST_REQ: begin
          // send wins over a timeout expiring in the same cycle.
          if (bus.send) begin
            done  <= 1'b1;
            rdata <= wr_q ? '0 : ext;
            req_q <= 1'b0;
            state <= ST_GAP;
            cnt   <= '0;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            done  <= 1'b1;
            err   <= 1'b1;
            rdata <= '0;
            req_q <= 1'b0;
            state <= ST_GAP;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_GAP: begin
          if (cnt == CW'(GAP - 1)) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
